lfsr_interval_timer: RTL and testbench

//  Programmable LFSR-based interval timer. Generalises the fixed 16-bit/1 ms LFSR tick with

---
 rtl/lfsr_interval_timer.sv | 117 +++++++++++
 tb/tb_lfsr_interval_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_interval_timer.sv
// rtl/lfsr_interval_timer.sv - programmable LFSR interval timer with one-shot/periodic modes
// Optional zero-lockup detection is enabled by defining LFSR_TIMER_LOCKUP_DET_EN.
module lfsr_interval_timer #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
    parameter logic [WIDTH-1:0] TERMINAL = 16'hF315,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_terminal,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] timeout_count,
    output logic             lock_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_nxt;
    logic [WIDTH-1:0] terminal, terminal_nxt;
    logic             mode_q, mode_nxt;
    logic             timeout_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             feedback;

    assign feedback = ^(lfsr & TAPS);

`ifdef LFSR_TIMER_LOCKUP_DET_EN
    logic lock_q, lock_nxt;
    assign lock_err = lock_q;
`else
    assign lock_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= SEED;
            terminal      <= TERMINAL;
            mode_q        <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
            timeout_count <= '0;
`ifdef LFSR_TIMER_LOCKUP_DET_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            lfsr          <= lfsr_nxt;
            terminal      <= terminal_nxt;
            mode_q        <= mode_nxt;
            timeout       <= timeout_nxt;
            busy          <= (state_nxt == RUN);
            timeout_count <= count_nxt;
`ifdef LFSR_TIMER_LOCKUP_DET_EN
            lock_q        <= lock_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        terminal_nxt = terminal;
        mode_nxt     = mode_q;
        timeout_nxt  = 1'b0;
        count_nxt    = timeout_count;
`ifdef LFSR_TIMER_LOCKUP_DET_EN
        lock_nxt     = lock_q;
`endif
        case (state)
            IDLE: begin
                if (cfg_we) terminal_nxt = cfg_terminal;
                if (start && !stop) begin
                    lfsr_nxt  = SEED;
                    mode_nxt  = mode;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // stop beats both a restart and a simultaneous terminal match
                if (stop) begin
                    state_nxt = IDLE;
                    lfsr_nxt  = SEED;
                end else if (start) begin
                    lfsr_nxt = SEED;
                    mode_nxt = mode;
                end else if (enable) begin
`ifdef LFSR_TIMER_LOCKUP_DET_EN
                    if (lfsr == '0) begin
                        lfsr_nxt = SEED;
                        lock_nxt = 1'b1;
                    end else
`endif
                    if (lfsr == terminal) begin
                        timeout_nxt = 1'b1;
                        lfsr_nxt    = SEED;
                        count_nxt   = timeout_count + CNT_W'(1);
                        if (mode_q) state_nxt = IDLE;
                    end else begin
                        lfsr_nxt = {lfsr[WIDTH-2:0], feedback};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_interval_timer.sv
// tb/tb_lfsr_interval_timer.sv - self-checking bench for lfsr_interval_timer (4-bit configuration)
module tb_lfsr_interval_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, cfg_we = 1'b0;
    logic [3:0] cfg_terminal = 4'h0;
    logic       timeout, busy, lock_err;
    logic [3:0] timeout_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Published sequence from SEED=1; the model tracks only a position in this table.
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    int         m_idx  = 0;
    bit         m_run  = 0;
    bit         m_mode = 0;
    bit         m_to   = 0;
    logic [3:0] m_term = 4'h5;
    int         m_cnt  = 0;

    lfsr_interval_timer #(
        .WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .TERMINAL(4'h5), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
        .cfg_we(cfg_we), .cfg_terminal(cfg_terminal), .timeout(timeout), .busy(busy),
        .timeout_count(timeout_count), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_timeout"}, 32'(timeout), 32'(m_to));
        check({tag, "_busy"},    32'(busy),    32'(m_run));
        check({tag, "_count"},   32'(timeout_count), 32'(m_cnt % 16));
        check({tag, "_lock"},    32'(lock_err), 32'd0);
    endtask

    task automatic model_reset();
        m_idx = 0; m_run = 0; m_mode = 0; m_to = 0; m_term = 4'h5; m_cnt = 0;
    endtask

    task automatic model_edge();
        m_to = 0;
        if (m_run) begin
            if (stop) begin
                m_run = 0; m_idx = 0;
            end else if (start) begin
                m_idx = 0; m_mode = mode;
            end else if (enable) begin
                if (seq[m_idx] == m_term) begin
                    m_to = 1; m_idx = 0; m_cnt++;
                    if (m_mode) m_run = 0;
                end else begin
                    m_idx = (m_idx + 1) % 15;
                end
            end
        end else begin
            if (cfg_we) m_term = cfg_terminal;
            if (start && !stop) begin
                m_run = 1; m_idx = 0; m_mode = mode;
            end
        end
    endtask

    task automatic step(input string tag, input logic s, input logic sp, input logic en,
                        input logic md, input logic we, input logic [3:0] ct);
        start = s; stop = sp; enable = en; mode = md; cfg_we = we; cfg_terminal = ct;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        bit found;
        int saved_cnt;

        // 1: reset and idle hold
        #2;
        check_all("rst_active");
        #10 rst = 1'b0;
        for (int i = 0; i < 4; i++) step("idle_hold", 0, 0, 1, 0, 0, 4'h0);

        // reset terminal value (5, index 8) reached in one-shot mode
        step("t5_start", 1, 0, 1, 1, 0, 4'h0);
        for (int i = 0; i < 11; i++) step("t5_run", 0, 0, 1, 0, 0, 4'h0);

        // 2: one-shot, terminal 4 -> pulse after the third enabled edge
        step("os_cfg", 0, 0, 1, 0, 1, 4'h4);
        step("os_start", 1, 0, 1, 1, 0, 4'h0);
        step("os_e1", 0, 0, 1, 0, 0, 4'h0);
        step("os_e2", 0, 0, 1, 0, 0, 4'h0);
        step("os_e3", 0, 0, 1, 0, 0, 4'h0);
        check("os_pulse", 32'(timeout), 32'd1);
        check("os_busy_drop", 32'(busy), 32'd0);
        check("os_count", 32'(timeout_count), 32'd2);
        for (int i = 0; i < 6; i++) step("os_after", 0, 0, 1, 0, 0, 4'h0);

        // 3: periodic terminal 8 (last in sequence), 17 timeouts wrap the 4-bit counter
        saved_cnt = m_cnt;
        step("per_cfg", 0, 0, 1, 0, 1, 4'h8);
        step("per_start", 1, 0, 1, 0, 0, 4'h0);
        for (int i = 0; i < 17 * 15; i++) step("per_run", 0, 0, 1, 0, 0, 4'h0);
        check("per_wrap", 32'(timeout_count), 32'((saved_cnt + 17) % 16));
        check("per_last_pulse", 32'(timeout), 32'd1);
        step("per_stop", 0, 1, 1, 0, 0, 4'h0);

        // 4: periodic terminal 4 with enable toggling, then stop on the match cycle
        step("tog_cfg", 0, 0, 1, 0, 1, 4'h4);
        step("tog_start", 1, 0, 1, 0, 0, 4'h0);
        for (int i = 0; i < 24; i++) step("tog_run", 0, 0, 1'(i % 2), 0, 0, 4'h0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_run && seq[m_idx] == m_term) begin
                saved_cnt = m_cnt;
                step("tog_stop_match", 0, 1, 1, 0, 0, 4'h0);
                check("stopmatch_no_pulse", 32'(timeout), 32'd0);
                check("stopmatch_idle", 32'(busy), 32'd0);
                check("stopmatch_count", 32'(timeout_count), 32'(saved_cnt % 16));
                found = 1;
            end else begin
                step("tog_seek", 0, 0, 1, 0, 0, 4'h0);
            end
        end
        check("stopmatch_reached", 32'(found), 32'd1);
        step("startstop", 1, 1, 1, 0, 0, 4'h0);
        check("startstop_idle", 32'(busy), 32'd0);

        // 5: cfg_we during RUN ignored
        step("cfgrun_start", 1, 0, 1, 0, 0, 4'h0);
        step("cfgrun_we", 0, 0, 1, 0, 1, 4'h9);
        for (int i = 0; i < 10; i++) step("cfgrun_run", 0, 0, 1, 0, 0, 4'h0);

        // asynchronous reset mid-RUN
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_midrun");
        #2 rst = 1'b0;

        // randomized traffic against the table model
        for (int i = 0; i < 500; i++) begin
            logic [3:0] t;
            t = 4'($urandom_range(0, 15));
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0), t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
